// File: rtl/sonar_serial_rx14.sv
// rtl/sonar_serial_rx14.sv - 14-bit MSB-first serial frame receiver with held output word
// Optional sticky overrun flag enabled by defining SONAR_RX_OVERRUN_EN.
module sonar_serial_rx14 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        bit_en,
    input  logic        serial_in,
    input  logic        ack,
    input  logic        overrun_clr,
    output logic [13:0] data,
    output logic        data_valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'd13;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] shift_q, shift_d;
    logic [13:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        complete;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            shift_q <= 14'd0;
            data_q  <= 14'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = 4'd0;
                    shift_d = 14'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A start inside a frame restarts it; the held word is untouched.
                if (start) begin
                    cnt_d   = 4'd0;
                    shift_d = 14'd0;
                end else if (bit_en) begin
                    if (cnt_q == LAST_BIT) begin
                        data_d   = {shift_q[12:0], serial_in};
                        complete = 1'b1;
                        cnt_d    = 4'd0;
                        state_d  = IDLE;
                    end else begin
                        shift_d = {shift_q[12:0], serial_in};
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completing word always wins over ack; ack alone releases the held word.
    always_comb begin
        valid_d = valid_q;
        if (complete) begin
            valid_d = 1'b1;
        end else if (ack) begin
            valid_d = 1'b0;
        end
    end

`ifdef SONAR_RX_OVERRUN_EN
    logic overrun_q, overrun_d;
    logic overrun_ev;

    assign overrun_ev = complete && valid_q && !ack;

    always_comb begin
        overrun_d = overrun_q;
        if (overrun_ev) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;

    logic unused_shift_msb;
    assign unused_shift_msb = shift_q[13];
`else
    assign overrun = 1'b0;

    logic unused_inputs;
    assign unused_inputs = overrun_clr ^ shift_q[13];
`endif

    assign data       = data_q;
    assign data_valid = valid_q;
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_sonar_serial_rx14.sv
// tb/tb_sonar_serial_rx14.sv - scoreboard bench for sonar_serial_rx14
module tb_sonar_serial_rx14;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        bit_en;
    logic        serial_in;
    logic        ack;
    logic        overrun_clr;
    logic [13:0] data;
    logic        data_valid;
    logic        busy;
    logic        overrun;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [13:0] exp_q[$];
    logic        exp_ovr = 1'b0;

    sonar_serial_rx14 dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .bit_en      (bit_en),
        .serial_in   (serial_in),
        .ack         (ack),
        .overrun_clr (overrun_clr),
        .data        (data),
        .data_valid  (data_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic with_bit);
        start     = 1'b1;
        bit_en    = with_bit;
        serial_in = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        bit_en    = 1'b0;
        serial_in = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic pulse_clr();
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
    endtask

    task automatic send_bits(input logic [13:0] w, input int first, input int last,
                             input int gap, input logic ack_last, input logic clr_last);
        for (int i = first; i >= last; i--) begin
            bit_en      = 1'b1;
            serial_in   = w[i];
            ack         = ack_last && (i == 0);
            overrun_clr = clr_last && (i == 0);
            @(negedge clk);
            bit_en      = 1'b0;
            serial_in   = 1'b0;
            ack         = 1'b0;
            overrun_clr = 1'b0;
            if (i != last) idle(gap);
        end
    endtask

    task automatic expect_done(input string tag);
        logic [13:0] e;
        int          k;
        k = 0;
        while (busy === 1'b1 && k < 4) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
        chk({tag, "_sb"}, {15'd0, (exp_q.size() != 0)}, 16'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, {2'b00, data}, {2'b00, e});
        end
        chk({tag, "_valid"}, {15'd0, data_valid}, 16'd1);
        chk({tag, "_ovr"}, {15'd0, overrun}, {15'd0, exp_ovr});
    endtask

    initial begin
        resetn      = 1'b0;
        start       = 1'b0;
        bit_en      = 1'b0;
        serial_in   = 1'b0;
        ack         = 1'b0;
        overrun_clr = 1'b0;
        idle(2);
        chk("rst_data",  {2'b00, data}, 16'd0);
        chk("rst_valid", {15'd0, data_valid}, 16'd0);
        chk("rst_busy",  {15'd0, busy}, 16'd0);
        chk("rst_ovr",   {15'd0, overrun}, 16'd0);
        resetn = 1'b1;
        idle(1);

        // bits with no start must be ignored
        send_bits(14'h3FFF, 13, 0, 0, 1'b0, 1'b0);
        chk("idle_busy",  {15'd0, busy}, 16'd0);
        chk("idle_valid", {15'd0, data_valid}, 16'd0);
        chk("idle_data",  {2'b00, data}, 16'd0);

        // basic capture; the start cycle carries bit_en=1 that must not be sampled
        exp_q.push_back(14'h2A5B);
        pulse_start(1'b1);
        send_bits(14'h2A5B, 13, 1, 0, 1'b0, 1'b0);
        chk("basic_early", {15'd0, data_valid}, 16'd0);
        chk("basic_inbusy", {15'd0, busy}, 16'd1);
        send_bits(14'h2A5B, 0, 0, 0, 1'b0, 1'b0);
        expect_done("basic");
        pulse_ack();
        chk("ack_clr",  {15'd0, data_valid}, 16'd0);
        chk("ack_hold", {2'b00, data}, 16'h2A5B);

        // stalls: alternate-cycle bit_en plus a long gap after bit 7
        exp_q.push_back(14'h3FFF);
        pulse_start(1'b0);
        send_bits(14'h3FFF, 13, 7, 1, 1'b0, 1'b0);
        idle(20);
        chk("stall_valid", {15'd0, data_valid}, 16'd0);
        chk("stall_busy",  {15'd0, busy}, 16'd1);
        send_bits(14'h3FFF, 6, 1, 1, 1'b0, 1'b0);
        idle(1);
        chk("stall_early", {15'd0, data_valid}, 16'd0);
        send_bits(14'h3FFF, 0, 0, 0, 1'b0, 1'b0);
        expect_done("stall");
        pulse_ack();

        // abort: five ones, restart, then 0x0001
        exp_q.push_back(14'h0001);
        pulse_start(1'b0);
        send_bits(14'h3FFF, 13, 9, 0, 1'b0, 1'b0);
        pulse_start(1'b0);
        chk("abort_busy",  {15'd0, busy}, 16'd1);
        chk("abort_valid", {15'd0, data_valid}, 16'd0);
        chk("abort_data",  {2'b00, data}, 16'h3FFF);
        send_bits(14'h0001, 13, 0, 0, 1'b0, 1'b0);
        expect_done("abort");
        pulse_ack();

        // overrun: second word lands on an unacknowledged one
        exp_q.push_back(14'h1234);
        pulse_start(1'b0);
        send_bits(14'h1234, 13, 0, 0, 1'b0, 1'b0);
        expect_done("ovr_first");
`ifdef SONAR_RX_OVERRUN_EN
        exp_ovr = 1'b1;
`endif
        exp_q.push_back(14'h0ABC);
        pulse_start(1'b0);
        send_bits(14'h0ABC, 13, 0, 0, 1'b0, 1'b0);
        expect_done("ovr_second");
        pulse_clr();
        exp_ovr = 1'b0;
        chk("ovr_clr", {15'd0, overrun}, 16'd0);
        // set must beat a simultaneous clear
`ifdef SONAR_RX_OVERRUN_EN
        exp_ovr = 1'b1;
`endif
        exp_q.push_back(14'h0555);
        pulse_start(1'b0);
        send_bits(14'h0555, 13, 0, 0, 1'b0, 1'b1);
        expect_done("ovr_setwin");
        pulse_clr();
        exp_ovr = 1'b0;
        chk("ovr_clr2", {15'd0, overrun}, 16'd0);

        // ack coincident with completion
        pulse_ack();
        chk("sim_pre", {15'd0, data_valid}, 16'd0);
        exp_q.push_back(14'h1111);
        pulse_start(1'b0);
        send_bits(14'h1111, 13, 0, 0, 1'b0, 1'b0);
        expect_done("sim_first");
        exp_q.push_back(14'h2222);
        pulse_start(1'b0);
        send_bits(14'h2222, 13, 0, 0, 1'b1, 1'b0);
        expect_done("sim_ack");
        pulse_ack();
        chk("sim_ack_clr", {15'd0, data_valid}, 16'd0);
        pulse_ack();
        chk("ack_idle_valid", {15'd0, data_valid}, 16'd0);
        chk("ack_idle_data",  {2'b00, data}, 16'h2222);

        // asynchronous reset mid-frame
        pulse_start(1'b0);
        send_bits(14'h1555, 13, 5, 0, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_busy",  {15'd0, busy}, 16'd0);
        chk("arst_data",  {2'b00, data}, 16'd0);
        chk("arst_valid", {15'd0, data_valid}, 16'd0);
        chk("arst_ovr",   {15'd0, overrun}, 16'd0);
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        send_bits(14'h3FFF, 13, 0, 0, 1'b0, 1'b0);
        chk("post_rst_valid", {15'd0, data_valid}, 16'd0);
        chk("post_rst_busy",  {15'd0, busy}, 16'd0);
        chk("post_rst_data",  {2'b00, data}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
